ode_io_sequencer: RTL and testbench
===================================

Name: ode_io_sequencer

Overview:
Top-level phase controller for one ODE solve. Sequences the IO block through load, then solver compute, then result send, and owns the single shared RAM. Drives the IO block's INT/Load_Process request lines and the solver's start strobe, and muxes the RAM write and read ports to the current phase owner. A watchdog aborts any phase that stalls.

Parameters:
ADDRESS_WIDTH, 13, RAM address width
DATA_WIDTH, 64, RAM data width
TIMEOUT_WIDTH, 20, watchdog counter width; timeout at 2^TIMEOUT_WIDTH-1 cycles in a wait state

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
Host_Start  in  1  request a full load/solve/send cycle
Abort  in  1  cancel current cycle
INT  out  1  request strobe to IO block
Load_Process  out  1  1 = load request, 0 = send request (qualifies INT)
Done_Loading  in  1  IO block finished loading
Done_Sending  in  1  IO block finished sending
Solver_Start  out  1  one-cycle start strobe to solver
Solver_Done  in  1  solver finished
IO_WR_En  in  1  IO write enable
IO_Address_WR  in  ADDRESS_WIDTH  IO write address
IO_Data_WR  in  DATA_WIDTH  IO write data
IO_Address_RD_A / IO_Address_RD_B  in  ADDRESS_WIDTH  IO read addresses
Solver_WR_En  in  1  solver write enable
Solver_Address_WR  in  ADDRESS_WIDTH  solver write address
Solver_Data_WR  in  DATA_WIDTH  solver write data
Solver_Address_RD_A / Solver_Address_RD_B  in  ADDRESS_WIDTH  solver read addresses
RAM_WR_En  out  1  RAM write enable
RAM_Address_WR  out  ADDRESS_WIDTH  RAM write address
RAM_Data_WR  out  DATA_WIDTH  RAM write data
RAM_Address_RD_A / RAM_Address_RD_B  out  ADDRESS_WIDTH  RAM read addresses
Busy  out  1  high in every state except IDLE
Phase  out  2  0 idle/done, 1 load, 2 solve, 3 send
Timeout_Error  out  1  sticky watchdog flag
Cycle_Done  out  1  one-cycle pulse on successful completion

Behaviour:
- FSM states: IDLE, LOAD_REQ, LOADING, SOLVE_REQ, SOLVING, SEND_REQ, SENDING, DONE. All control outputs are Moore-decoded from the registered state.
- Reset: state IDLE, watchdog 0, Timeout_Error 0. All control outputs are 0; RAM_WR_En is 0.
- IDLE: Host_Start=1 moves to LOAD_REQ at the next edge and clears Timeout_Error. Host_Start is ignored in every other state.
- LOAD_REQ (1 cycle): INT=1, Load_Process=1. Moves to LOADING.
- LOADING: Load_Process=1. Done_Loading=1 moves to SOLVE_REQ.
- SOLVE_REQ (1 cycle): Solver_Start=1. Moves to SOLVING.
- SOLVING: Solver_Done=1 moves to SEND_REQ.
- SEND_REQ (1 cycle): INT=1, Load_Process=0. Moves to SENDING.
- SENDING: Done_Sending=1 moves to DONE.
- DONE (1 cycle): Cycle_Done=1. Moves to IDLE.
- Done_* and Solver_Done are ignored outside their own wait state.
- Minimum cycle, Host_Start to Cycle_Done, with each done asserted on the first wait cycle: 7 cycles.
- Phase: LOAD_REQ/LOADING=1, SOLVE_REQ/SOLVING=2, SEND_REQ/SENDING=3, else 0.
- RAM port ownership is combinational from state:
  - Solver owns the RAM in SOLVE_REQ/SOLVING.
  - IO owns it in all other states.
  - RAM_Address_WR, RAM_Data_WR, RAM_Address_RD_A and RAM_Address_RD_B pass the owner's signals through.
- Write gating:
  - RAM_WR_En = IO_WR_En only in LOADING.
  - RAM_WR_En = Solver_WR_En only in SOLVING.
  - RAM_WR_En = 0 in all other states. Non-owner write enables never reach the RAM.
- Watchdog:
  - Counter clears on entry to LOADING, SOLVING or SENDING, and increments every cycle in those states.
  - When it reaches all-ones with the exit condition still false: Timeout_Error is set and held, and the FSM returns to IDLE next edge. Cycle_Done is not pulsed.
  - Exit condition true on the terminal cycle: the normal transition wins.
- Abort=1 in any non-IDLE state: IDLE at the next edge, no error, no Cycle_Done. Abort outranks done inputs and timeout in the same cycle.
- RST outranks everything: a reset mid-phase returns to IDLE at once, with ownership back to IO and write enable off.

Test Plan:
- Full cycle, TIMEOUT_WIDTH=4:
  - Stimulus: Host_Start at cycle 0; Done_Loading at 3; Solver_Done at 6; Done_Sending at 9.
  - Response: INT/Load_Process=1/1 at cycle 1; Solver_Start at cycle 4; INT=1 with Load_Process=0 at cycle 7; Cycle_Done at cycle 10; Phase sequence 1,1,1,2,2,2,3,3,3,0.
- Ownership mux:
  - Stimulus: in LOADING, IO_WR_En=1, IO_Address_WR=0x005, data 0xA5, while Solver_WR_En=1 with address 0x1FF.
  - Response: RAM gets 0x005/0xA5; solver write suppressed. In SOLVING the solver's 0x1FF is passed through and IO's write is blocked.
- Watchdog, TIMEOUT_WIDTH=4:
  - Stimulus: Solver_Done never asserted.
  - Response: 15 cycles after entering SOLVING, Timeout_Error=1 and state IDLE. The next Host_Start clears the flag.
- Abort:
  - Stimulus: Abort mid-SENDING, with Done_Sending=1 in the same cycle.
  - Response: IDLE next cycle, Cycle_Done stays 0.
- Request filtering:
  - Stimulus: Host_Start pulses during SOLVING; stray Done_Loading during SENDING.
  - Response: no state change, no extra INT.
- Reset mid-operation:
  - Stimulus: RST in LOADING while IO_WR_En=1.
  - Response: next cycle IDLE, RAM_WR_En=0, Busy=0, all strobes 0.

Source files
------------

// File: rtl/ode_io_sequencer.sv
// ode_io_sequencer
// ----------------
// Phase controller for one ODE solve. A host request walks the design through
// three phases: the IO block loads the shared RAM, the solver computes in it,
// and the IO block sends the results out. This block raises the request strobes
// for each phase and waits for the matching done input. It also steers the
// single RAM's write and read ports to whichever agent owns the current phase.
// A watchdog bounds every wait state. A host abort or a reset returns the
// controller to idle.
//
// Ports
//   CLK, RST                    clock (rising edge), synchronous active-high reset
//   Host_Start, Abort           host request / cancel
//   INT, Load_Process           IO request strobe; Load_Process=1 load, 0 send
//   Done_Loading, Done_Sending  IO block completion inputs
//   Solver_Start, Solver_Done   solver start strobe / completion input
//   IO_*, Solver_*              candidate RAM write/read port signals per agent
//   RAM_*                       muxed RAM port driven to the memory
//   Busy, Phase                 status: not idle / 0 idle, 1 load, 2 solve, 3 send
//   Timeout_Error               sticky watchdog flag, cleared by the next start
//   Cycle_Done                  one-cycle pulse on successful completion
module ode_io_sequencer #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64,
    parameter int TIMEOUT_WIDTH = 20
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Host_Start,
    input  logic                     Abort,
    output logic                     INT,
    output logic                     Load_Process,
    input  logic                     Done_Loading,
    input  logic                     Done_Sending,
    output logic                     Solver_Start,
    input  logic                     Solver_Done,
    input  logic                     IO_WR_En,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_WR,
    input  logic [DATA_WIDTH-1:0]    IO_Data_WR,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_RD_A,
    input  logic [ADDRESS_WIDTH-1:0] IO_Address_RD_B,
    input  logic                     Solver_WR_En,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_WR,
    input  logic [DATA_WIDTH-1:0]    Solver_Data_WR,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_RD_A,
    input  logic [ADDRESS_WIDTH-1:0] Solver_Address_RD_B,
    output logic                     RAM_WR_En,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_WR,
    output logic [DATA_WIDTH-1:0]    RAM_Data_WR,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B,
    output logic                     Busy,
    output logic [1:0]               Phase,
    output logic                     Timeout_Error,
    output logic                     Cycle_Done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_REQ,
        LOADING,
        SOLVE_REQ,
        SOLVING,
        SEND_REQ,
        SENDING,
        DONE
    } state_t;

    // The counter holds the number of completed cycles in the current wait
    // state. The terminal cycle is the one whose increment would reach
    // all-ones, so a wait state lasts at most 2^TIMEOUT_WIDTH-1 cycles.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    state_t                   state;
    state_t                   state_nxt;
    logic [TIMEOUT_WIDTH-1:0] wd_cnt;
    logic                     wd_last;
    logic                     wd_trip;
    logic                     in_wait;
    logic                     solver_owns;

    assign in_wait = (state == LOADING) || (state == SOLVING) || (state == SENDING);
    assign wd_last = (wd_cnt == WD_LAST);

    // Next-state selection. Priority, highest first: abort, then the exit
    // condition of the wait state, then the watchdog.
    always_comb begin
        state_nxt = state;
        wd_trip   = 1'b0;
        case (state)
            IDLE:      if (Host_Start) state_nxt = LOAD_REQ;
            LOAD_REQ:  state_nxt = LOADING;
            LOADING: begin
                if (Done_Loading) state_nxt = SOLVE_REQ;
                else if (wd_last) wd_trip = 1'b1;
            end
            SOLVE_REQ: state_nxt = SOLVING;
            SOLVING: begin
                if (Solver_Done) state_nxt = SEND_REQ;
                else if (wd_last) wd_trip = 1'b1;
            end
            SEND_REQ:  state_nxt = SENDING;
            SENDING: begin
                if (Done_Sending) state_nxt = DONE;
                else if (wd_last) wd_trip = 1'b1;
            end
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if ((state != IDLE) && Abort) begin
            state_nxt = IDLE;
            wd_trip   = 1'b0;
        end else if (wd_trip) begin
            state_nxt = IDLE;
        end
    end

    // The control outputs are decoded from the next state and registered, so
    // each one is a clean Moore function of the current state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            wd_cnt        <= '0;
            Timeout_Error <= 1'b0;
            INT           <= 1'b0;
            Load_Process  <= 1'b0;
            Solver_Start  <= 1'b0;
            Cycle_Done    <= 1'b0;
            Busy          <= 1'b0;
            Phase         <= 2'd0;
        end else begin
            state  <= state_nxt;
            // The counter sits at zero outside the wait states, so it is
            // already clear on entry to a wait state.
            wd_cnt <= in_wait ? wd_cnt + 1'b1 : '0;
            if (wd_trip)
                Timeout_Error <= 1'b1;
            else if ((state == IDLE) && Host_Start)
                Timeout_Error <= 1'b0;
            INT          <= (state_nxt == LOAD_REQ) || (state_nxt == SEND_REQ);
            Load_Process <= (state_nxt == LOAD_REQ) || (state_nxt == LOADING);
            Solver_Start <= (state_nxt == SOLVE_REQ);
            Cycle_Done   <= (state_nxt == DONE);
            Busy         <= (state_nxt != IDLE);
            case (state_nxt)
                LOAD_REQ, LOADING:  Phase <= 2'd1;
                SOLVE_REQ, SOLVING: Phase <= 2'd2;
                SEND_REQ, SENDING:  Phase <= 2'd3;
                default:            Phase <= 2'd0;
            endcase
        end
    end

    // RAM ownership follows the registered state. Write enables are passed
    // through only in the owner's active wait state. The request-strobe
    // cycles never write.
    assign solver_owns = (state == SOLVE_REQ) || (state == SOLVING);

    always_comb begin
        RAM_WR_En = 1'b0;
        if (state == LOADING)
            RAM_WR_En = IO_WR_En;
        else if (state == SOLVING)
            RAM_WR_En = Solver_WR_En;
        RAM_Address_WR   = solver_owns ? Solver_Address_WR   : IO_Address_WR;
        RAM_Data_WR      = solver_owns ? Solver_Data_WR      : IO_Data_WR;
        RAM_Address_RD_A = solver_owns ? Solver_Address_RD_A : IO_Address_RD_A;
        RAM_Address_RD_B = solver_owns ? Solver_Address_RD_B : IO_Address_RD_B;
    end

endmodule

// File: tb/tb_ode_io_sequencer.sv
module tb_ode_io_sequencer;
    localparam int AW = 13;
    localparam int DW = 64;
    localparam int TW = 4;
    localparam int WAIT_MAX = (1 << TW) - 1;

    logic          CLK = 1'b0;
    logic          RST, Host_Start, Abort, Done_Loading, Done_Sending, Solver_Done;
    logic          INT, Load_Process, Solver_Start, Busy, Timeout_Error, Cycle_Done;
    logic [1:0]    Phase;
    logic          IO_WR_En, Solver_WR_En, RAM_WR_En;
    logic [AW-1:0] IO_Address_WR, IO_Address_RD_A, IO_Address_RD_B;
    logic [AW-1:0] Solver_Address_WR, Solver_Address_RD_A, Solver_Address_RD_B;
    logic [AW-1:0] RAM_Address_WR, RAM_Address_RD_A, RAM_Address_RD_B;
    logic [DW-1:0] IO_Data_WR, Solver_Data_WR, RAM_Data_WR;

    ode_io_sequencer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_WIDTH(TW)) dut (
        .CLK(CLK), .RST(RST), .Host_Start(Host_Start), .Abort(Abort),
        .INT(INT), .Load_Process(Load_Process),
        .Done_Loading(Done_Loading), .Done_Sending(Done_Sending),
        .Solver_Start(Solver_Start), .Solver_Done(Solver_Done),
        .IO_WR_En(IO_WR_En), .IO_Address_WR(IO_Address_WR), .IO_Data_WR(IO_Data_WR),
        .IO_Address_RD_A(IO_Address_RD_A), .IO_Address_RD_B(IO_Address_RD_B),
        .Solver_WR_En(Solver_WR_En), .Solver_Address_WR(Solver_Address_WR),
        .Solver_Data_WR(Solver_Data_WR),
        .Solver_Address_RD_A(Solver_Address_RD_A), .Solver_Address_RD_B(Solver_Address_RD_B),
        .RAM_WR_En(RAM_WR_En), .RAM_Address_WR(RAM_Address_WR), .RAM_Data_WR(RAM_Data_WR),
        .RAM_Address_RD_A(RAM_Address_RD_A), .RAM_Address_RD_B(RAM_Address_RD_B),
        .Busy(Busy), .Phase(Phase), .Timeout_Error(Timeout_Error), .Cycle_Done(Cycle_Done)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: a step in the load/solve/send walk plus the number of
    // cycles spent so far in the current wait step.
    localparam int M_IDLE = 0, M_LREQ = 1, M_LOAD = 2, M_SREQ = 3,
                   M_SOLVE = 4, M_XREQ = 5, M_SEND = 6, M_DONE = 7;
    int m_st   = M_IDLE;
    int m_wait = 0;
    bit m_err  = 1'b0;

    function automatic bit m_is_wait(input int s);
        return (s == M_LOAD) || (s == M_SOLVE) || (s == M_SEND);
    endfunction

    function automatic logic [1:0] m_phase(input int s);
        if (s == M_LREQ || s == M_LOAD)  return 2'd1;
        if (s == M_SREQ || s == M_SOLVE) return 2'd2;
        if (s == M_XREQ || s == M_SEND)  return 2'd3;
        return 2'd0;
    endfunction

    always @(posedge CLK) begin
        int  nxt;
        bit  done_in;
        nxt = m_st;
        if (RST) begin
            nxt   = M_IDLE;
            m_err = 1'b0;
        end else if (m_st == M_IDLE) begin
            if (Host_Start) begin
                nxt   = M_LREQ;
                m_err = 1'b0;
            end
        end else if (Abort) begin
            nxt = M_IDLE;
        end else if (m_is_wait(m_st)) begin
            done_in = (m_st == M_LOAD) ? Done_Loading :
                      (m_st == M_SOLVE) ? Solver_Done : Done_Sending;
            if (done_in)
                nxt = m_st + 1;
            else if (m_wait == WAIT_MAX) begin
                nxt   = M_IDLE;
                m_err = 1'b1;
            end
        end else begin
            nxt = (m_st == M_DONE) ? M_IDLE : m_st + 1;
        end
        if (m_is_wait(nxt))
            m_wait = (nxt == m_st) ? m_wait + 1 : 1;
        else
            m_wait = 0;
        m_st = nxt;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (started) begin
            logic [7:0]    e_ctl;
            logic          e_wr;
            bit            sol;
            #2;
            sol   = (m_st == M_SREQ) || (m_st == M_SOLVE);
            e_ctl = {(m_st == M_LREQ || m_st == M_XREQ),
                     (m_st == M_LREQ || m_st == M_LOAD),
                     (m_st == M_SREQ), (m_st == M_DONE),
                     (m_st != M_IDLE), m_phase(m_st), m_err};
            e_wr  = (m_st == M_LOAD) ? IO_WR_En : (m_st == M_SOLVE) ? Solver_WR_En : 1'b0;
            chk("ctl", {INT, Load_Process, Solver_Start, Cycle_Done, Busy, Phase, Timeout_Error}, e_ctl);
            chk("ram_we", RAM_WR_En, e_wr);
            chk("ram_wa", RAM_Address_WR, sol ? Solver_Address_WR : IO_Address_WR);
            chk("ram_wd", RAM_Data_WR, sol ? Solver_Data_WR : IO_Data_WR);
            chk("ram_ra", {RAM_Address_RD_A, RAM_Address_RD_B},
                sol ? {Solver_Address_RD_A, Solver_Address_RD_B} : {IO_Address_RD_A, IO_Address_RD_B});
        end
    end

    task automatic nxt_cyc();
        @(negedge CLK);
        RST = 0; Host_Start = 0; Abort = 0;
        Done_Loading = 0; Done_Sending = 0; Solver_Done = 0;
        IO_WR_En = 0; Solver_WR_En = 0;
    endtask

    initial begin
        RST = 1; Host_Start = 0; Abort = 0;
        Done_Loading = 0; Done_Sending = 0; Solver_Done = 0;
        IO_WR_En = 0; Solver_WR_En = 0;
        IO_Address_WR = '0; IO_Data_WR = '0; IO_Address_RD_A = 13'h011; IO_Address_RD_B = 13'h012;
        Solver_Address_WR = '0; Solver_Data_WR = '0;
        Solver_Address_RD_A = 13'h0A1; Solver_Address_RD_B = 13'h0A2;
        @(negedge CLK);
        started = 1'b1;
        #3;
        chk("rst_ctl", {INT, Load_Process, Solver_Start, Cycle_Done, Busy, Phase, Timeout_Error}, 8'h00);
        chk("rst_we", RAM_WR_En, 1'b0);

        // Full cycle with ownership, filtering and stray-done checks.
        for (int c = 0; c <= 11; c++) begin
            nxt_cyc();
            case (c)
                2: begin
                    IO_WR_En = 1; IO_Address_WR = 13'h005; IO_Data_WR = 64'hA5;
                    Solver_WR_En = 1; Solver_Address_WR = 13'h1FF; Solver_Data_WR = 64'h77;
                end
                3: Done_Loading = 1;
                5: begin Solver_WR_En = 1; IO_WR_En = 1; Host_Start = 1; end
                6: begin Solver_Done = 1; IO_WR_En = 1; end
                8: Done_Loading = 1;
                9: Done_Sending = 1;
                0: Host_Start = 1;
                default: ;
            endcase
            #3;
            case (c)
                1: begin chk("c1_int_lp", {INT, Load_Process}, 2'b11); chk("c1_phase", Phase, 2'd1);
                         chk("model_c1_phase", m_phase(m_st), 2'd1); end
                2: begin chk("own_io_we", RAM_WR_En, 1'b1); chk("own_io_wa", RAM_Address_WR, 13'h005);
                         chk("own_io_wd", RAM_Data_WR, 64'hA5); chk("c2_lp", {INT, Load_Process}, 2'b01); end
                4: begin chk("c4_start", Solver_Start, 1'b1); chk("c4_phase", Phase, 2'd2); end
                5: begin chk("own_sol_we", RAM_WR_En, 1'b1); chk("own_sol_wa", RAM_Address_WR, 13'h1FF);
                         chk("own_sol_wd", RAM_Data_WR, 64'h77); chk("own_sol_ra", RAM_Address_RD_A, 13'h0A1); end
                6: begin chk("io_blocked", RAM_WR_En, 1'b0); chk("c6_phase", Phase, 2'd2); end
                7: begin chk("c7_int_lp", {INT, Load_Process}, 2'b10); chk("c7_phase", Phase, 2'd3); end
                9: begin chk("stray_phase", Phase, 2'd3); chk("stray_int", INT, 1'b0); end
                10: begin chk("c10_done", Cycle_Done, 1'b1); chk("c10_phase", Phase, 2'd0);
                          chk("model_c10_done", (m_st == M_DONE), 1'b1); end
                11: chk("c11_idle", {Cycle_Done, Busy}, 2'b00);
                default: ;
            endcase
        end

        // Watchdog in SOLVING, then clear by a new start, then abort in LOAD_REQ.
        for (int c = 0; c <= 23; c++) begin
            nxt_cyc();
            if (c == 0 || c == 21) Host_Start = 1;
            if (c == 2) Done_Loading = 1;
            if (c == 22) Abort = 1;
            #3;
            if (c == 18) chk("wd_pre", {Phase, Timeout_Error}, 3'b100);
            if (c == 19) begin
                chk("wd_trip", {Busy, Phase, Timeout_Error, Cycle_Done}, 5'b00010);
                chk("model_wd_err", m_err, 1'b1);
            end
            if (c == 22) chk("wd_clear", {Phase, Timeout_Error}, 3'b010);
            if (c == 23) chk("abort_lreq", Busy, 1'b0);
        end

        // Exit on the terminal watchdog cycle wins.
        for (int c = 0; c <= 19; c++) begin
            nxt_cyc();
            if (c == 0) Host_Start = 1;
            if (c == 2) Done_Loading = 1;
            if (c == 18) Solver_Done = 1;
            #3;
            if (c == 19) chk("wd_exit_wins", {Phase, Timeout_Error}, 3'b110);
        end
        repeat (20) nxt_cyc();

        // Abort mid-SENDING with Done_Sending in the same cycle.
        for (int c = 0; c <= 9; c++) begin
            nxt_cyc();
            if (c == 0) Host_Start = 1;
            if (c == 2) Done_Loading = 1;
            if (c == 4) Solver_Done = 1;
            if (c == 7) begin Abort = 1; Done_Sending = 1; end
            #3;
            if (c == 7) chk("abort_pre", Phase, 2'd3);
            if (c == 8) chk("abort_idle", {Busy, Phase, Cycle_Done}, 4'b0000);
            if (c == 9) chk("abort_nodone", Cycle_Done, 1'b0);
        end

        // Reset while loading with the IO write enable held high.
        for (int c = 0; c <= 4; c++) begin
            nxt_cyc();
            if (c == 0) Host_Start = 1;
            if (c >= 2) IO_WR_En = 1;
            if (c == 3) RST = 1;
            #3;
            if (c == 3) chk("rst_pre_we", RAM_WR_En, 1'b1);
            if (c == 4) begin
                chk("rst_mid_we", RAM_WR_En, 1'b0);
                chk("rst_mid_ctl", {INT, Load_Process, Solver_Start, Cycle_Done, Busy, Phase}, 7'h00);
            end
        end

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            nxt_cyc();
            RST          = ($urandom_range(0, 199) == 0);
            Host_Start   = ($urandom_range(0, 3) == 0);
            Abort        = ($urandom_range(0, 39) == 0);
            Done_Loading = ($urandom_range(0, 5) == 0);
            Done_Sending = ($urandom_range(0, 5) == 0);
            Solver_Done  = ($urandom_range(0, 5) == 0);
            IO_WR_En     = $urandom_range(0, 1);
            Solver_WR_En = $urandom_range(0, 1);
            IO_Address_WR       = AW'($urandom);
            IO_Address_RD_A     = AW'($urandom);
            IO_Address_RD_B     = AW'($urandom);
            Solver_Address_WR   = AW'($urandom);
            Solver_Address_RD_A = AW'($urandom);
            Solver_Address_RD_B = AW'($urandom);
            IO_Data_WR     = {$urandom, $urandom};
            Solver_Data_WR = {$urandom, $urandom};
        end
        nxt_cyc();
        nxt_cyc();
        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
